i2c_fnd_mux_slave: RTL

- Parametrised I2C slave driving an N-digit multiplexed common-anode 7-segment display.
- Successor to the single-digit FND slave. Adds:
  - a register pointer with auto-increment;
  - multi-byte burst writes;
  - read-back of digit registers;
  - repeated-START handling;
  - a per-digit decimal point and blank bit;
  - a built-in refresh scanner.
- Sits on the shared SCL/SDA bus beside the other slaves; drives the board SEG/DP/AN pins directly.

---
 rtl/i2c_pkg.sv | 48 ++++
 rtl/fnd_scan.sv | 46 ++++
 rtl/i2c_fnd_mux_slave.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: FSM state encoding,
// ACK/NACK bus levels and the hex-to-7-segment decoder.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    RX_DEV_ADDR  = 4'd1,
    DEV_ADDR_ACK = 4'd2,
    RX_PTR       = 4'd3,
    PTR_ACK      = 4'd4,
    RX_DATA      = 4'd5,
    RX_DATA_ACK  = 4'd6,
    TX_DATA      = 4'd7,
    TX_MACK      = 4'd8,
    WAIT_STOP    = 4'd9
  } state_t;

  // SDA levels during the acknowledge bit
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h7F;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fnd_scan.sv
// Multiplexed 7-segment refresh scanner.
// In: clk, rst, digits_i (packed 8-bit digit regs). Out: seg_o, dp_o, an_o (active low).
module fnd_scan
  import i2c_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 25000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS*8-1:0] digits_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o
);

  localparam int CW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [3:0]    hexv;
  logic          dp_bit;
  logic          blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_q <= '0;
      idx_q <= (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign hexv   = digits_i[{idx_q, 3'b000} +: 4];
  assign dp_bit = digits_i[{idx_q, 3'b100}];
  assign blank  = digits_i[{idx_q, 3'b111}];

  // Blank suppresses the decimal point as well
  assign seg_o = blank ? 7'h7F : hex2seg(hexv);
  assign dp_o  = ~(dp_bit & ~blank);
  assign an_o  = ~(NUM_DIGITS'(1) << idx_q);

endmodule

// File: rtl/i2c_fnd_mux_slave.sv
// I2C slave with auto-incrementing pointer into N digit registers driving a muxed display.
// Ports: clk, rst, scl, sda (open drain), SEG/DP/AN (active low), debug_state, debug_ptr.
module i2c_fnd_mux_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h56,
  parameter int NUM_DIGITS = 4,
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [3:0]            debug_state,
  output logic [2:0]            debug_ptr
);

  localparam int DIV_RAW  = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int SCAN_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;

  state_t                  state_q;
  logic [2:0]              scl_q, sda_q;
  logic [2:0]              ptr_q;
  logic [3:0]              cnt_q;
  logic [7:0]              shift_q;
  logic [7:0]              tx_q;
  logic                    rw_q;
  logic                    sda_oe_q;
  logic [NUM_DIGITS*8-1:0] digits_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] cur;
  logic [2:0] ptr_nxt;

  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] & scl_q[2] & ~sda_q[1] &  sda_q[2];
  assign stop_det  =  scl_q[1] & scl_q[2] &  sda_q[1] & ~sda_q[2];

  assign cur     = digits_q[{ptr_q, 3'b000} +: 8];
  assign ptr_nxt = (ptr_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : ptr_q + 3'd1;

  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q    <= 3'b111;
      sda_q    <= 3'b111;
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      tx_q     <= '0;
      rw_q     <= 1'b0;
      sda_oe_q <= 1'b0;
      digits_q <= {NUM_DIGITS{8'h80}};
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
      if (stop_det) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
      end else if (start_det) begin
        state_q  <= RX_DEV_ADDR;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
      end else begin
        unique case (state_q)
          RX_DEV_ADDR, RX_PTR, RX_DATA: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], sda_q[1]};
              cnt_q   <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              cnt_q <= '0;
              if (state_q == RX_DEV_ADDR) begin
                if (shift_q[7:1] == SLAVE_ADDR) begin
                  rw_q     <= shift_q[0];
                  state_q  <= DEV_ADDR_ACK;
                  sda_oe_q <= ~ACK;
                end else begin
                  state_q <= WAIT_STOP;
                end
              end else if (state_q == RX_PTR) begin
                if (shift_q < 8'(NUM_DIGITS)) begin
                  ptr_q    <= shift_q[2:0];
                  state_q  <= PTR_ACK;
                  sda_oe_q <= ~ACK;
                end else begin
                  state_q  <= WAIT_STOP;
                  sda_oe_q <= ~NACK;
                end
              end else begin
                state_q  <= RX_DATA_ACK;
                sda_oe_q <= ~ACK;
              end
            end
          end
          DEV_ADDR_ACK: begin
            if (scl_fall) begin
              if (rw_q) begin
                // First TX bit goes out on the same edge that ends the ACK
                state_q  <= TX_DATA;
                tx_q     <= cur;
                sda_oe_q <= ~cur[7];
              end else begin
                state_q  <= RX_PTR;
                sda_oe_q <= 1'b0;
              end
            end
          end
          PTR_ACK: begin
            if (scl_fall) begin
              state_q  <= RX_DATA;
              sda_oe_q <= 1'b0;
            end
          end
          RX_DATA_ACK: begin
            if (scl_fall) begin
              digits_q[{ptr_q, 3'b000} +: 8] <= shift_q;
              ptr_q    <= ptr_nxt;
              state_q  <= RX_DATA;
              sda_oe_q <= 1'b0;
            end
          end
          TX_DATA: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                cnt_q    <= '0;
                state_q  <= TX_MACK;
                sda_oe_q <= 1'b0;
              end else begin
                tx_q     <= {tx_q[6:0], 1'b0};
                sda_oe_q <= ~tx_q[6];
              end
            end
          end
          TX_MACK: begin
            if (scl_rise) begin
              if (sda_q[1] == NACK) state_q <= WAIT_STOP;
              else                  ptr_q   <= ptr_nxt;
            end else if (scl_fall) begin
              state_q  <= TX_DATA;
              tx_q     <= cur;
              sda_oe_q <= ~cur[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign debug_state = state_q;
  assign debug_ptr   = ptr_q;

  fnd_scan #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .digits_i(digits_q),
    .seg_o   (SEG),
    .dp_o    (DP),
    .an_o    (AN)
  );

endmodule
